// File: rtl/mp_add_pkg.sv
// Shared types for the multi-precision limb adder: default limb width,
// sequencer state encoding and the registered output record.
package mp_add_pkg;

  localparam int LIMB_W_DEFAULT = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [LIMB_W_DEFAULT-1:0] sum;
    logic                      first;
    logic                      last;
    logic                      cout;
    logic                      ovf;
  } out_rec_t;

endpackage

// File: rtl/mp_limb_adder_if.sv
// Limb-stream bus: operand limb pairs in, sum limbs out, each side with
// its own valid/ready handshake.
interface mp_limb_adder_if #(
  parameter int LIMB_W = mp_add_pkg::LIMB_W_DEFAULT
);

  logic              in_valid;
  logic              in_ready;
  logic [LIMB_W-1:0] in_a;
  logic [LIMB_W-1:0] in_b;
  logic              in_first;
  logic              in_last;
  logic              in_sub;

  logic              out_valid;
  logic              out_ready;
  logic [LIMB_W-1:0] out_sum;
  logic              out_first;
  logic              out_last;
  logic              out_cout;
  logic              out_ovf;

  modport slave (
    input  in_valid, in_a, in_b, in_first, in_last, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_first, out_last, out_cout, out_ovf
  );

  modport master (
    output in_valid, in_a, in_b, in_first, in_last, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_first, out_last, out_cout, out_ovf
  );

endinterface

// File: rtl/limb_add_cin.sv
// Combinational Kogge-Stone adder with carry-in; returns the limb sum and
// the carry out of the most significant bit.
module limb_add_cin #(
  parameter int LIMB_W = mp_add_pkg::LIMB_W_DEFAULT
) (
  input  logic [LIMB_W-1:0] a,
  input  logic [LIMB_W-1:0] b,
  input  logic              cin,
  output logic [LIMB_W-1:0] sum,
  output logic              cout
);

  localparam int LEVELS = $clog2(LIMB_W);

  logic [LIMB_W-1:0] gen [LEVELS+1];
  logic [LIMB_W-1:0] prop [LEVELS+1];
  logic [LIMB_W-1:0] carry;

  // Folding cin into bit 0's generate makes every prefix term a true carry-out.
  always_comb begin
    prop[0]   = a ^ b;
    gen[0]    = a & b;
    gen[0][0] = (a[0] & b[0]) | ((a[0] ^ b[0]) & cin);
    for (int l = 0; l < LEVELS; l++) begin
      for (int i = 0; i < LIMB_W; i++) begin
        if (i >= (1 << l)) begin
          gen[l+1][i]  = gen[l][i] | (prop[l][i] & gen[l][i - (1 << l)]);
          prop[l+1][i] = prop[l][i] & prop[l][i - (1 << l)];
        end else begin
          gen[l+1][i]  = gen[l][i];
          prop[l+1][i] = prop[l][i];
        end
      end
    end
  end

  assign carry = {gen[LEVELS][LIMB_W-2:0], cin};
  assign sum   = prop[0] ^ carry;
  assign cout  = gen[LEVELS][LIMB_W-1];

endmodule

// File: rtl/mp_limb_adder.sv
// Multi-precision add/subtract sequencer: chains the carry across a stream
// of limb pairs (LS first) and registers one result limb per accepted limb.
module mp_limb_adder
  import mp_add_pkg::*;
#(
  parameter int LIMB_W = LIMB_W_DEFAULT,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  mp_limb_adder_if.slave    bus,
  output logic              err
);

  state_t            state, state_n;
  logic              carry_q;
  logic              sub_q;
  logic [CNT_W-1:0]  cnt;
  logic              out_valid_q;
  out_rec_t          out_q;

  logic              accept;
  logic              sub_eff;
  logic [LIMB_W-1:0] b_eff;
  logic              cin;
  logic [LIMB_W-1:0] sum;
  logic              c;
  logic              ovf;
  logic              drop;
  logic              force_last;
  logic              last_eff;
  logic              err_n;
  out_rec_t          rec_n;

  assign bus.in_ready = ~out_valid_q | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;

  // A first limb always restarts with its own sub flag, even mid-operation.
  assign sub_eff = bus.in_first ? bus.in_sub : sub_q;
  assign b_eff   = sub_eff ? ~bus.in_b : bus.in_b;
  assign cin     = bus.in_first ? bus.in_sub : carry_q;

  limb_add_cin #(.LIMB_W(LIMB_W)) u_add (
    .a    (bus.in_a),
    .b    (b_eff),
    .cin  (cin),
    .sum  (sum),
    .cout (c)
  );

  assign ovf = (bus.in_a[LIMB_W-1] == b_eff[LIMB_W-1]) && (sum[LIMB_W-1] != bus.in_a[LIMB_W-1]);

  always_comb begin
    state_n    = state;
    drop       = 1'b0;
    force_last = 1'b0;
    err_n      = 1'b0;
    if (accept) begin
      if (bus.in_first) begin
        err_n   = (state == RUN);
        state_n = bus.in_last ? IDLE : RUN;
      end else if (state == IDLE) begin
        drop  = 1'b1;
        err_n = 1'b1;
      end else begin
        force_last = (cnt == {CNT_W{1'b1}}) && !bus.in_last;
        err_n      = force_last;
        state_n    = (bus.in_last || force_last) ? IDLE : RUN;
      end
    end
    last_eff    = bus.in_last | force_last;
    rec_n.sum   = sum;
    rec_n.first = bus.in_first;
    rec_n.last  = last_eff;
    rec_n.cout  = last_eff & c;
    rec_n.ovf   = last_eff & ovf;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      carry_q     <= 1'b0;
      sub_q       <= 1'b0;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      err         <= 1'b0;
    end else begin
      state <= state_n;
      err   <= err_n;
      if (accept && !drop) begin
        carry_q     <= c;
        out_q       <= rec_n;
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (accept && bus.in_first) begin
        sub_q <= bus.in_sub;
        cnt   <= CNT_W'(1);
      end else if (accept && state == RUN) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_q.sum;
  assign bus.out_first = out_q.first;
  assign bus.out_last  = out_q.last;
  assign bus.out_cout  = out_q.cout;
  assign bus.out_ovf   = out_q.ovf;

endmodule

// File: tb/tb_mp_limb_adder.sv
// Directed bench for mp_limb_adder: hand-computed limb results, backpressure,
// protocol errors, reset abandonment and the limb-count limit.
module tb_mp_limb_adder;

  logic clk;
  logic reset;
  logic err;
  int   checks;
  int   errors;

  mp_limb_adder_if #(.LIMB_W(8)) bus ();

  mp_limb_adder #(.LIMB_W(8), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] b,
                                input logic first, input logic last, input logic sub);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_first = first;
    bus.in_last  = last;
    bus.in_sub   = sub;
  endtask

  task automatic idle_input();
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks a full output limb: valid, sum, first, last, cout, ovf.
  task automatic check_limb(input string tag, input logic [7:0] sum, input logic first,
                            input logic last, input logic cout, input logic ovf);
    check_output({tag, ".valid"}, 32'(bus.out_valid), 32'(1'b1));
    check_output({tag, ".sum"},   32'(bus.out_sum),   32'(sum));
    check_output({tag, ".first"}, 32'(bus.out_first), 32'(first));
    check_output({tag, ".last"},  32'(bus.out_last),  32'(last));
    check_output({tag, ".cout"},  32'(bus.out_cout),  32'(cout));
    check_output({tag, ".ovf"},   32'(bus.out_ovf),   32'(ovf));
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_sub    = 1'b0;
    idle_input();
    step();
    step();
    check_output("rst.valid", 32'(bus.out_valid), 32'd0);
    check_output("rst.sum",   32'(bus.out_sum),   32'd0);
    check_output("rst.last",  32'(bus.out_last),  32'd0);
    check_output("rst.cout",  32'(bus.out_cout),  32'd0);
    check_output("rst.err",   32'(err),           32'd0);
    check_output("rst.ready", 32'(bus.in_ready),  32'd1);
    reset = 1'b0;

    $display("[TB] single limb FF+FF");
    apply_stimulus(8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0);
    step();
    check_limb("t1", 8'hFE, 1'b1, 1'b1, 1'b1, 1'b0);
    idle_input();
    step();
    check_output("t1.drain", 32'(bus.out_valid), 32'd0);

    $display("[TB] 16-bit adds and sub");
    apply_stimulus(8'hFF, 8'h01, 1'b1, 1'b0, 1'b0);
    step();
    check_limb("t2.l0", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(8'h01, 8'h00, 1'b0, 1'b1, 1'b0);
    step();
    check_limb("t2.l1", 8'h02, 1'b0, 1'b1, 1'b0, 1'b0);
    apply_stimulus(8'hFF, 8'h01, 1'b1, 1'b0, 1'b0);
    step();
    check_limb("t3a.l0", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(8'hFF, 8'h00, 1'b0, 1'b1, 1'b0);
    step();
    check_limb("t3a.l1", 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    apply_stimulus(8'h00, 8'h01, 1'b1, 1'b0, 1'b1);
    step();
    check_limb("t3b.l0", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(8'h01, 8'h00, 1'b0, 1'b1, 1'b0);
    step();
    check_limb("t3b.l1", 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);

    $display("[TB] signed overflow");
    apply_stimulus(8'h7F, 8'h01, 1'b1, 1'b1, 1'b0);
    step();
    check_limb("ovf.add", 8'h80, 1'b1, 1'b1, 1'b0, 1'b1);
    apply_stimulus(8'h80, 8'h01, 1'b1, 1'b1, 1'b1);
    step();
    check_limb("ovf.sub", 8'h7F, 1'b1, 1'b1, 1'b1, 1'b1);

    $display("[TB] backpressure");
    apply_stimulus(8'h10, 8'h20, 1'b1, 1'b0, 1'b0);
    step();
    check_limb("t4.l0", 8'h30, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    apply_stimulus(8'h30, 8'h40, 1'b0, 1'b0, 1'b0);
    #1;
    check_output("t4.inready", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_limb("t4.hold", 8'h30, 1'b1, 1'b0, 1'b0, 1'b0);
      check_output("t4.hold.ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    step();
    check_limb("t4.l1", 8'h70, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(8'h50, 8'h60, 1'b0, 1'b1, 1'b0);
    step();
    check_limb("t4.l2", 8'hB0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle_input();
    step();
    check_output("t4.drain", 32'(bus.out_valid), 32'd0);

    $display("[TB] protocol errors");
    apply_stimulus(8'h11, 8'h22, 1'b0, 1'b1, 1'b0);
    step();
    check_output("t5a.valid", 32'(bus.out_valid), 32'd0);
    check_output("t5a.err",   32'(err),           32'd1);
    idle_input();
    step();
    check_output("t5a.errclr", 32'(err), 32'd0);
    apply_stimulus(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
    step();
    check_limb("t5b.l0", 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0);
    check_output("t5b.err0", 32'(err), 32'd0);
    apply_stimulus(8'h01, 8'h01, 1'b1, 1'b1, 1'b0);
    step();
    check_limb("t5b.restart", 8'h02, 1'b1, 1'b1, 1'b0, 1'b0);
    check_output("t5b.err", 32'(err), 32'd1);
    idle_input();
    step();
    check_output("t5b.errclr", 32'(err), 32'd0);

    $display("[TB] reset mid-operation");
    apply_stimulus(8'h01, 8'h02, 1'b1, 1'b0, 1'b0);
    step();
    check_limb("t6.l0", 8'h03, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_input();
    reset = 1'b1;
    step();
    check_output("t6.valid", 32'(bus.out_valid), 32'd0);
    check_output("t6.err0",  32'(err),           32'd0);
    reset = 1'b0;
    apply_stimulus(8'h05, 8'h06, 1'b0, 1'b1, 1'b0);
    step();
    check_output("t6.drop", 32'(bus.out_valid), 32'd0);
    check_output("t6.err",  32'(err),           32'd1);

    $display("[TB] limb count limit");
    for (int i = 0; i < 15; i++) begin
      apply_stimulus(8'hFF, 8'h00, (i == 0), 1'b0, 1'b0);
      step();
      check_output("lim.last", 32'(bus.out_last), 32'd0);
      check_output("lim.sum",  32'(bus.out_sum),  32'hFF);
    end
    apply_stimulus(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    step();
    check_limb("lim.force", 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    check_output("lim.err", 32'(err), 32'd1);
    apply_stimulus(8'h01, 8'h01, 1'b0, 1'b1, 1'b0);
    step();
    check_output("lim.idle", 32'(bus.out_valid), 32'd0);
    check_output("lim.idle.err", 32'(err), 32'd1);
    idle_input();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
